clk_period_meter: RTL

Measures the period and high time of an asynchronous periodic input, such as a divided fabric clock or a CAN bit-rate reference, in system-clock cycles. The result is delivered as one measurement record over a valid/ready handshake. It sits beside the clock-divider logic as its checking counterpart: a divider generates a slow clock, and this block confirms its frequency and duty cycle on silicon and in bench loopback.

---
 rtl/clk_period_meter_pkg.sv | 22 ++
 rtl/sync_rise_det.sv | 37 +++
 rtl/clk_period_meter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/clk_period_meter_pkg.sv
// ============================================================================
// Module   : clk_period_meter_pkg
// Brief    : Shared state encoding and constants for the clock period meter.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package clk_period_meter_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_rise_det.sv
// ============================================================================
// Module   : sync_rise_det
// Brief    : Multi-flop synchronizer with a one-cycle rising-edge strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_rise_det
    import clk_period_meter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '0;
            sync_dly_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_i};
            sync_dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~sync_dly_q;

endmodule

`default_nettype wire

// File: rtl/clk_period_meter.sv
// ============================================================================
// Module   : clk_period_meter
// Brief    : Measures period and high time of an async periodic input in clk
//            cycles; CLK_PERIOD_METER_CONT_EN selects continuous re-arming.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module clk_period_meter
    import clk_period_meter_pkg::*;
#(
    parameter int          CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] period_cycles,
    output logic [CNT_W-1:0] high_cycles,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    logic s_sync;
    logic rise;

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] hi_q,      hi_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] high_q,    high_d;
    logic             timeout_q, timeout_d;

    sync_rise_det u_sync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .sync_o (s_sync),
        .rise_o (rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            period_q  <= '0;
            high_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            period_q  <= period_d;
            high_q    <= high_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        period_d  = period_q;
        high_d    = high_q;
        timeout_d = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_EDGE;
                    cnt_d   = '0;
                end
            end
            WAIT_EDGE: begin
                // The opening rise cycle itself is counted as one high cycle.
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = ONE;
                    hi_d    = ONE;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    period_d  = '0;
                    high_d    = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            MEASURE: begin
                // A closing edge on the limit cycle still yields a good record.
                if (rise) begin
                    state_d   = DONE;
                    period_d  = cnt_q;
                    high_d    = hi_q;
                    timeout_d = 1'b0;
                end else if (cnt_q == TIMEOUT_LIM) begin
                    state_d   = DONE;
                    period_d  = TIMEOUT_LIM;
                    high_d    = hi_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                    hi_d  = hi_q + CNT_W'(s_sync);
                end
            end
            DONE: begin
                if (meas_ready) begin
`ifdef CLK_PERIOD_METER_CONT_EN
                    state_d = WAIT_EDGE;
                    cnt_d   = '0;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q != IDLE);
    assign meas_valid    = (state_q == DONE);
    assign period_cycles = period_q;
    assign high_cycles   = high_q;
    assign timeout       = timeout_q;

endmodule

`default_nettype wire
